spi_slave_responder: RTL and testbench



---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_input_sync.sv | 29 ++
 rtl/spi_slave_responder.sv | 179 +++++++++++++++++
 tb/tb_spi_slave_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link constants and FSM state type
package spi_pkg;
  localparam int         SPI_DATA_WIDTH   = 8;
  localparam logic [7:0] NRF_STATUS_RESET = 8'h0E;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_t;
endpackage

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - SYNC_STAGES-deep synchronizer with rise/fall detect on the last stage
module spi_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_dly  <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_dly;
  assign o_fall = ~o_sync & r_dly;
endmodule

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 slave with rx strobe and one-entry tx holding register
// Optional macro SPI_SLAVE_RESPONDER_ECHO_EN: underrun loads echo the last received word.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = DATA_WIDTH'(NRF_STATUS_RESET)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  csn_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_first,
  output logic                  tx_underrun,
  output logic                  frame_active
);
  localparam int              CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic w_sck_rise, w_sck_fall, w_unused_sck_level;
  logic w_csn_sync, w_csn_rise, w_csn_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;

  spi_state_t r_state, w_state_next;
  logic w_start, w_abort, w_sample, w_shift, w_load, w_tx_write;

  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-2:0] r_shift_in;
  logic [DATA_WIDTH-1:0] r_shift_out;
  logic [DATA_WIDTH-1:0] w_word_in;
  logic [DATA_WIDTH-1:0] w_empty_word;
  logic                  r_first, r_load_pending;
  logic [DATA_WIDTH-1:0] r_rx_data, r_hold;
  logic                  r_rx_valid, r_rx_first, r_underrun, r_hold_full;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .reset(reset), .i_async(sck),
    .o_sync(w_unused_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csn_sync (
    .clk(clk), .reset(reset), .i_async(csn_n),
    .o_sync(w_csn_sync), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );

  // mosi is only sampled on a detected sck rise, so it needs no edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mosi_sync <= '0;
    else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

`ifdef SPI_SLAVE_RESPONDER_ECHO_EN
  logic r_rx_seen;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_rx_seen <= 1'b0;
    else if (r_rx_valid) r_rx_seen <= 1'b1;
  end
  assign w_empty_word = r_rx_seen ? r_rx_data : DEFAULT_TX;
`else
  assign w_empty_word = DEFAULT_TX;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= SPI_IDLE;
    else       r_state <= w_state_next;
  end

  // csn_rise outranks any sck edge in the same clk; a csn_fall while ACTIVE is a glitch
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_sample     = 1'b0;
    w_shift      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      SPI_IDLE: begin
        if (w_csn_fall) begin
          w_state_next = SPI_ACTIVE;
          w_start      = 1'b1;
          w_load       = 1'b1;
        end
      end
      SPI_ACTIVE: begin
        if (w_csn_rise) begin
          w_state_next = SPI_IDLE;
          w_abort      = 1'b1;
        end else begin
          w_sample = w_sck_rise;
          w_load   = w_sck_fall & r_load_pending;
          w_shift  = w_sck_fall & ~r_load_pending;
        end
      end
      default: w_state_next = SPI_IDLE;
    endcase
  end

  assign w_word_in  = {r_shift_in, w_mosi};
  assign w_tx_write = tx_valid & ~r_hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt      <= '0;
      r_shift_in     <= '0;
      r_shift_out    <= '0;
      r_first        <= 1'b0;
      r_load_pending <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_first     <= 1'b0;
      r_underrun     <= 1'b0;
      r_hold         <= '0;
      r_hold_full    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_first <= 1'b0;
      r_underrun <= 1'b0;
      if (w_start) begin
        r_bit_cnt      <= '0;
        r_first        <= 1'b1;
        r_load_pending <= 1'b0;
      end
      if (w_abort) begin
        r_bit_cnt      <= '0;
        r_load_pending <= 1'b0;
      end
      if (w_sample) begin
        r_shift_in <= w_word_in[DATA_WIDTH-2:0];
        if (r_bit_cnt == LAST_BIT) begin
          r_rx_data      <= w_word_in;
          r_rx_valid     <= 1'b1;
          r_rx_first     <= r_first;
          r_first        <= 1'b0;
          r_bit_cnt      <= '0;
          r_load_pending <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
      // a write only lands while empty, so it never collides with the load draining the register
      if (w_load) begin
        r_load_pending <= 1'b0;
        if (r_hold_full) begin
          r_shift_out <= r_hold;
          r_hold_full <= 1'b0;
        end else begin
          r_shift_out <= w_empty_word;
          r_underrun  <= 1'b1;
        end
      end else if (w_shift) begin
        r_shift_out <= r_shift_out << 1;
      end
      if (w_tx_write) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign miso         = r_shift_out[DATA_WIDTH-1];
  assign frame_active = ~w_csn_sync;
  assign miso_oe      = frame_active;
  assign tx_ready     = ~r_hold_full;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_first     = r_rx_first;
  assign tx_underrun  = r_underrun;
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - randomized scoreboard bench for spi_slave_responder
`timescale 1ns/1ps
module tb_spi_slave_responder;
  localparam int         SYNC = 2;
  localparam int         HALF = 5;
  localparam logic [7:0] DEF  = 8'h0E;

  logic       clk = 1'b0;
  logic       reset, sck, csn_n, mosi;
  logic       miso, miso_oe, tx_ready, rx_valid, rx_first, tx_underrun, frame_active;
  logic       tx_valid;
  logic [7:0] tx_data, rx_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int obs_underruns = 0;
  int mbits = 0;
  logic [7:0] mword = 8'h00;

  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic       exp_first_q[$];
  logic [7:0] fr_q[$];

  logic       m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic       m_rx_seen = 1'b0;
  logic [7:0] m_last_rx = 8'h00;
  int         m_underruns = 0;

  spi_slave_responder #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC), .DEFAULT_TX(DEF)) dut (
    .clk(clk), .reset(reset), .sck(sck), .csn_n(csn_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_underrun(tx_underrun), .frame_active(frame_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a one-deep mailbox; an empty mailbox yields the fallback word and counts an underrun
  task automatic model_load(output logic [7:0] w);
    if (m_full) begin
      w      = m_hold;
      m_full = 1'b0;
    end else begin
      m_underruns++;
`ifdef SPI_SLAVE_RESPONDER_ECHO_EN
      w = m_rx_seen ? m_last_rx : DEF;
`else
      w = DEF;
`endif
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_underrun) obs_underruns++;
      if (rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no word", rx_data);
        end else begin
          check("rx_data", rx_data, exp_rx_q.pop_front());
          check("rx_first", rx_first, exp_first_q.pop_front());
          check("rx_latency", cyc - rise_cyc, SYNC + 1);
        end
      end
    end
  end

  always @(posedge sck or posedge csn_n or posedge reset) begin
    if (reset || csn_n) begin
      mbits = 0;
    end else begin
      mword = {mword[6:0], miso};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        if (exp_tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_unexpected: got 0x%0h, expected no word", mword);
        end else begin
          check("miso_word", mword, exp_tx_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_first", rx_first, 0);
    check("rst_tx_underrun", tx_underrun, 0);
    check("rst_frame_active", frame_active, 0);
  endtask

  task automatic preload(input logic [7:0] v);
    @(negedge clk);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_hold = v;
    end
    @(negedge clk);
    check("tx_ready_after_write", tx_ready, 0);
  endtask

  // abort_bits>0 truncates the last word; cw_idx>=1 writes cw_val in the clk of the load before word cw_idx
  task automatic send_frame(input int abort_bits, input int cw_idx, input logic [7:0] cw_val);
    int         n, nb;
    logic [7:0] w;
    logic       was_full, last;
    n = fr_q.size();
    @(negedge clk);
    csn_n = 1'b0;
    mosi  = fr_q[0][7];
    model_load(w);
    for (int i = 0; i < n; i++) begin
      nb = (i == n - 1 && abort_bits > 0) ? abort_bits : 8;
      if (nb == 8) exp_tx_q.push_back(w);
      for (int b = 0; b < nb; b++) begin
        repeat (HALF) @(negedge clk);
        sck      = 1'b1;
        rise_cyc = cyc;
        if (i == 0 && b == 0) begin
          check("frame_active_in", frame_active, 1);
          check("miso_oe_in", miso_oe, 1);
          check("tx_ready_in", tx_ready, !m_full);
        end
        if (b == nb - 1 && nb == 8) begin
          exp_rx_q.push_back(fr_q[i]);
          exp_first_q.push_back(i == 0);
          m_last_rx = fr_q[i];
          m_rx_seen = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        last = (i == n - 1) && (b == nb - 1);
        if (last && abort_bits == 0) begin
          sck   = 1'b0;
          csn_n = 1'b1;
        end else begin
          sck = 1'b0;
          if (b < nb - 1) mosi = fr_q[i][6-b];
          else if (i < n - 1) mosi = fr_q[i+1][7];
          if (b == nb - 1 && i < n - 1) begin
            was_full = m_full;
            model_load(w);
            if (cw_idx == i + 1) begin
              if (!was_full) begin
                m_hold = cw_val;
                m_full = 1'b1;
              end
              repeat (SYNC) @(negedge clk);
              tx_data  = cw_val;
              tx_valid = 1'b1;
              @(negedge clk);
              tx_valid = 1'b0;
            end
          end
        end
      end
    end
    if (abort_bits > 0) begin
      repeat (HALF) @(negedge clk);
      csn_n = 1'b1;
    end
    repeat (HALF + 3) @(negedge clk);
    check("frame_active_out", frame_active, 0);
    check("miso_oe_out", miso_oe, 0);
    check("tx_ready_out", tx_ready, !m_full);
    check("underrun_count", obs_underruns, m_underruns);
    check("miso_queue_drained", exp_tx_q.size(), 0);
    check("rx_queue_drained", exp_rx_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    int         n, ab, cw;
    reset = 1'b1; sck = 1'b0; csn_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    repeat (3) @(negedge clk);

    fr_q = '{8'h11, 8'h22};
    send_frame(0, -1, 8'h00);

    preload(8'hA5);
    fr_q = '{8'h20};
    send_frame(0, -1, 8'h00);

    fr_q = '{8'h61, 8'hFF, 8'hFF};
    send_frame(0, -1, 8'h00);

    fr_q = '{8'h5A};
    send_frame(5, -1, 8'h00);
    fr_q = '{8'h33, 8'hCC};
    send_frame(0, -1, 8'h00);

    fr_q = '{8'hC3, 8'h96, 8'h5A};
    send_frame(0, 1, 8'h3C);

    @(negedge clk);
    csn_n = 1'b0;
    mosi  = 1'b1;
    model_load(w);
    for (int b = 0; b < 3; b++) begin
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck  = 1'b0;
      mosi = ~mosi;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals();
    csn_n = 1'b1; sck = 1'b0;
    m_full = 1'b0; m_rx_seen = 1'b0; m_last_rx = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    fr_q = '{8'hA7, 8'h5E};
    send_frame(0, -1, 8'h00);

    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 4);
      fr_q.delete();
      for (int i = 0; i < n; i++) fr_q.push_back(8'($urandom));
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      cw = (n >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
      if ($urandom_range(0, 1) == 1 && !m_full) preload(8'($urandom));
      send_frame(ab, cw, 8'($urandom));
    end

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
